// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: PC generation, imem alignment, one-entry hold buffer for decode stalls, redirect kill.
module rv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_Q100H,
  input  logic [31:0] instruction_Q101H,
  input  logic        ready_Q101H,
  input  logic        redirect_valid_Q102H,
  input  logic [31:0] redirect_target_Q102H,
  output logic        valid_Q101H,
  output logic [31:0] pc_Q101H,
  output logic [31:0] instr_Q101H,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_f;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic        advance;
  assign pc_Q100H    = pc_f;
  assign advance     = !valid_Q101H || ready_Q101H;
  assign instr_Q101H = !valid_Q101H ? NOP_INSTR : (hold_valid ? hold_instr : instruction_Q101H);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      pc_Q101H    <= '0;
      valid_Q101H <= 1'b0;
      hold_valid  <= 1'b0;
      hold_instr  <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (valid_Q101H && ready_Q101H) fetch_count <= fetch_count + 32'd1;
      if (redirect_valid_Q102H) begin
        pc_f        <= {redirect_target_Q102H[31:2], 2'b00};
        valid_Q101H <= 1'b0;
        hold_valid  <= 1'b0;
        if (redirect_target_Q102H[1:0] != 2'b00) fetch_err <= 1'b1;
      end else if (advance) begin
        pc_Q101H    <= pc_f;
        valid_Q101H <= 1'b1;
        pc_f        <= pc_f + 32'd4;
        hold_valid  <= 1'b0;
      end else if (!hold_valid) begin
        // imem has moved on to pc_f, so capture the stalled word once
        hold_instr <= instruction_Q101H;
        hold_valid <= 1'b1;
      end
    end
  end
endmodule

// File: doc/rv_fetch_stage.md
# rv_fetch_stage

Instruction fetch stage (Q100H/Q101H) of the RV core. Generates the fetch PC driven to the synchronous instruction memory and aligns the returned word with its PC. Presents a valid/PC/instruction triple to decode. Handles decode back-pressure with a one-entry hold buffer and kills in-flight fetches on a branch/jump redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction driven to decode when not valid (addi x0,x0,0)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- pc_Q100H  out  32  fetch address to imem; imem returns mem[pc_Q100H] one cycle later
- instruction_Q101H  in  32  imem read data for the previous cycle's pc_Q100H
- ready_Q101H  in  1  decode accepts the Q101H instruction this cycle
- redirect_valid_Q102H  in  1  taken branch/jump resolved in execute
- redirect_target_Q102H  in  32  redirect byte address
- valid_Q101H  out  1  instr_Q101H/pc_Q101H hold a live instruction
- pc_Q101H  out  32  PC of instr_Q101H
- instr_Q101H  out  32  instruction to decode
- fetch_err  out  1  sticky: a redirect target had bits [1:0] != 0
- fetch_count  out  32  instructions accepted by decode (valid_Q101H & ready_Q101H)

## Operation
- Registers: pc_f (drives pc_Q100H), pc_Q101H, valid_Q101H, hold_valid, hold_instr, fetch_err, fetch_count.
- instr_Q101H = !valid_Q101H ? NOP_INSTR : (hold_valid ? hold_instr : instruction_Q101H).
- advance = !valid_Q101H | ready_Q101H.
- Priority per clock edge: rst > redirect > advance > stall.
- Redirect (redirect_valid_Q102H=1):
  - pc_f <= {target[31:2],2'b00}; valid_Q101H <= 0; hold_valid <= 0.
  - fetch_err <= 1 if target[1:0] != 0.
  - Overrides ready_Q101H; the Q101H instruction is still counted if it is accepted that cycle.
- Advance without redirect: pc_Q101H <= pc_f; valid_Q101H <= 1; pc_f <= pc_f + 4 (mod 2^32, wraps at 32'hFFFF_FFFC -> 0); hold_valid <= 0.
- Stall (valid_Q101H & !ready_Q101H, no redirect):
  - pc_f and pc_Q101H hold.
  - If hold_valid=0: hold_instr <= instruction_Q101H, hold_valid <= 1. This is required because imem now returns mem[pc_f], not mem[pc_Q101H].
  - If hold_valid=1: hold_instr unchanged.
- fetch_count += 1 on valid_Q101H & ready_Q101H. Wraps at 2^32.
- Reset values: pc_f=RESET_PC (so pc_Q100H=RESET_PC during and after reset), pc_Q101H=0, valid_Q101H=0, instr_Q101H=NOP_INSTR, hold_valid=0, fetch_err=0, fetch_count=0. Reset mid-stall or mid-redirect discards all state; nothing from before reset reaches decode.

## Timing
- Fetch latency: address at pc_Q100H in cycle t -> matching valid instruction at Q101H in cycle t+1 when not stalled.
- After rst falls, first edge: valid_Q101H=1, pc_Q101H=RESET_PC.
- Steady state: one instruction per cycle, pc_Q101H increments by 4.
- Redirect sampled at edge r:
  - cycle r+1: pc_Q100H=T, valid_Q101H=0.
  - cycle r+2: valid_Q101H=1, pc_Q101H=T, instr=mem[T].
  - Penalty is 2 bubbles.
- Stall of N cycles: the same pc_Q101H/instr_Q101H is presented all N+1 cycles. On release, the next cycle shows pc+4 with correct data and no bubble.
- Redirect during stall: the held instruction is dropped; timing is as for any redirect.
- Back-to-back redirects: the last one wins, and no instruction from the earlier target becomes valid.
- ready_Q101H while valid_Q101H=0 has no effect.

## Test plan
- Reset release, RESET_PC=0, imem[i]=i, ready=1 -> valid rises the first cycle after reset; pc_Q101H=0,4,8,…; instr=0,1,2,…; fetch_count=3 after 3 cycles.
- Stall: ready=0 for 3 cycles while pc_Q101H=8 -> pc_Q101H=8, instr=mem[2] held 4 cycles; after release, pc_Q101H=12 with instr=mem[3]; no duplicates or skips; fetch_count increments once for pc 8.
- Redirect to 32'h40 while pc_Q101H=0x10 -> next cycle valid=0, instr=32'h0000_0013, pc_Q100H=0x40; cycle after, pc_Q101H=0x40 with instr=mem[0x10].
- Redirect during 2-cycle stall, plus back-to-back redirects 0x80 then 0xC0 -> held instruction is never accepted; only pc 0xC0 becomes valid next.
- Misaligned target 32'h0000_0046 -> pc_Q100H=0x44, fetch_err=1 and stays 1 until rst.
- Wrap and mid-run reset:
  - RESET_PC=32'hFFFF_FFF8 -> pc_Q101H sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - rst asserted during a stall -> valid=0, hold cleared, fetch_count=0; after rst falls, restart at RESET_PC.
